if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PcWidth, default 8, program-counter width in bits (matches ProgramCounter).
REQ-002 SHALL have parameter ResetPc, default 8'h00, PC value loaded on reset.
REQ-003 SHALL have parameter CntWidth, default 16, width of the performance counters.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stall  input  1  hazard-unit stall request (stallIF).
REQ-007 SHALL have port branch  input  1  branch instruction resolving this cycle.
REQ-008 SHALL have port alu_zero  input  1  branch comparison result; taken when branch=1 and alu_zero=1.
REQ-009 SHALL have port jmp  input  1  jump resolving this cycle.
REQ-010 SHALL have port pc_branch  input  PcWidth  branch target.
REQ-011 SHALL have port pc_jmp  input  PcWidth  jump target.
REQ-012 SHALL have port imem_addr  output  PcWidth  instruction-memory read address.
REQ-013 SHALL have port imem_rdata  input  32  instruction word at imem_addr, combinational read.
REQ-014 SHALL have port pc  output  PcWidth  current fetch PC (IF_output.pc).
REQ-015 SHALL have port id_instr  output  32  IF/ID register: fetched instruction.
REQ-016 SHALL have port id_pc  output  PcWidth  IF/ID register: PC+1 of fetched instruction.
REQ-017 SHALL have port id_valid  output  1  IF/ID register holds a real instruction (0 = bubble).
REQ-018 SHALL have port fetch_cnt  output  CntWidth  count of instructions delivered to ID.
REQ-019 SHALL have port flush_cnt  output  CntWidth  count of redirects (flushes).

Function
REQ-020 SHALL drive imem_addr = pc combinationally; all other outputs SHALL be registered.
REQ-021 SHALL define redirect = jmp OR (branch AND alu_zero); branch with alu_zero=0 SHALL NOT redirect.
REQ-022 SHALL resolve per-cycle priority as redirect > stall > normal advance.
REQ-023 Redirect: pc <= pc_jmp if jmp=1, else pc_branch (jmp wins when both); id_instr <= 32'h0, id_pc <= 0, id_valid <= 0; stall is ignored.
REQ-024 Stall without redirect: pc, id_instr, id_pc, id_valid SHALL all hold their values.
REQ-025 Normal advance: pc <= pc+1 modulo 2^PcWidth (8'hFF wraps to 8'h00); id_instr <= imem_rdata; id_pc <= pc+1 (same wrap); id_valid <= 1.
REQ-026 Fetch latency SHALL be one cycle: the word at address A appears on id_instr the edge after pc=A with no stall or redirect.
REQ-027 fetch_cnt SHALL increment by 1 on each normal advance, saturating at all-ones.
REQ-028 flush_cnt SHALL increment by 1 on each redirect cycle, including one that coincides with stall, saturating at all-ones.
REQ-029 Back-to-back redirects SHALL each load their own target and each insert one bubble.

Reset
REQ-030 On rst_n=0, asynchronously and regardless of clk: pc=ResetPc, id_instr=32'h0, id_pc=0, id_valid=0, fetch_cnt=0, flush_cnt=0.
REQ-031 While rst_n=0, all inputs SHALL be ignored; reset asserted mid-stall or mid-redirect SHALL discard the pending update.
REQ-032 The first rising edge with rst_n=1 SHALL perform a normal fetch from ResetPc (unless stall or redirect is asserted).

Verification
REQ-033 Reset, then 3 free cycles with imem_rdata = 8C010004, 8C020008, 00221820 -> pc 01, 02, 03; id_instr follows one cycle later; id_pc 01, 02, 03; fetch_cnt=3.
REQ-034 At pc=05, stall=1 for 2 cycles -> pc, id_instr, id_pc stay 05, word@04, 05; fetch_cnt unchanged; advance resumes when stall=0.
REQ-035 branch=1, alu_zero=1, pc_branch=8'h20, stall=1 -> next pc=20, id_valid=0, id_instr=0, flush_cnt+1; branch=1, alu_zero=0 -> normal advance.
REQ-036 jmp=1, pc_jmp=8'h40 with branch=1, alu_zero=1, pc_branch=8'h20 -> pc=40, one bubble; flush_cnt+1.
REQ-037 pc=FF, free cycle -> pc=00, id_pc=00; fetch_cnt preset to FFFF by 65535 advances -> stays FFFF on the next advance.
REQ-038 rst_n pulsed low between edges while pc=12 and stall=1 -> pc=ResetPc and all outputs zero immediately; first fetch after release comes from ResetPc.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect/stall arbitration, IF/ID pipeline register, perf counters.
// Latency: one cycle from imem_addr to id_instr; stall holds PC and IF/ID, redirect overrides stall.
module if_stage #(
    parameter int                 PcWidth  = 8,
    parameter logic [PcWidth-1:0] ResetPc  = 8'h00,
    parameter int                 CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch,
    input  logic                alu_zero,
    input  logic                jmp,
    input  logic [PcWidth-1:0]  pc_branch,
    input  logic [PcWidth-1:0]  pc_jmp,
    output logic [PcWidth-1:0]  imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [PcWidth-1:0]  pc,
    output logic [31:0]         id_instr,
    output logic [PcWidth-1:0]  id_pc,
    output logic                id_valid,
    output logic [CntWidth-1:0] fetch_cnt,
    output logic [CntWidth-1:0] flush_cnt
);

    logic               redirect;
    logic               advance;
    logic [PcWidth-1:0] pc_inc;
    logic [PcWidth-1:0] redirect_target;

    // A not-taken branch is just a normal advance.
    assign redirect        = jmp | (branch & alu_zero);
    assign advance         = ~redirect & ~stall;
    assign pc_inc          = pc + PcWidth'(1);
    assign redirect_target = jmp ? pc_jmp : pc_branch;
    assign imem_addr       = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= ResetPc;
            id_instr <= 32'h0;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_target;
            id_instr <= 32'h0;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (advance) begin
            pc       <= pc_inc;
            id_instr <= imem_rdata;
            id_pc    <= pc_inc;
            id_valid <= 1'b1;
        end
    end

    // Saturating counters: stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (advance && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + CntWidth'(1);
            end
            if (redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CntWidth'(1);
            end
        end
    end

endmodule
